// File: rtl/perf_snapshot_ctrl_pkg.sv
// Shared constants for the perf-counter snapshot sequencer: FSM encodings,
// record geometry, header layout and the counter CSR base address.
package perf_snapshot_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_CMPL = 3'd4;

  localparam int unsigned PERF_REC_WORDS = 8;
  localparam int unsigned PERF_REC_BYTES = 64;
  localparam int unsigned HDR_MASK_LSB   = 56;
  localparam int unsigned HDR_MASK_W     = 8;

  localparam logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03;

  function automatic logic [63:0] rec_word_addr(input logic [63:0] base,
                                                input logic [15:0] idx,
                                                input logic [2:0]  word);
    return base + (64'(idx) * 64'(PERF_REC_BYTES)) + (64'(word) << 3);
  endfunction

endpackage

// File: rtl/perf_snapshot_ctrl.sv
// Dumps a timestamped snapshot of the perf counters into a memory ring buffer
// whenever any counter signals a threshold crossing.
//
// state | meaning
// IDLE  | waiting for an enabled trigger or pending mask
// HDR   | offering header word (mask + cycle count)
// RD    | reading counter k from the perf counter block
// WR    | offering counter k
// CMPL  | advance ring pointer, raise irq
module perf_snapshot_ctrl
  import perf_snapshot_ctrl_pkg::*;
#(
  parameter int unsigned NumCounters = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [NumCounters-1:0] trig_i,
  input  logic [63:0]            cycle_count_i,
  input  logic [63:0]            base_addr_i,
  input  logic [15:0]            buf_entries_i,
  output logic [11:0]            perf_addr_o,
  input  logic [63:0]            perf_rdata_i,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [63:0]            mem_addr_o,
  output logic [63:0]            mem_wdata_o,
  output logic                   irq_o,
  input  logic                   irq_clr_i,
  output logic                   busy_o,
  output logic [15:0]            wr_ptr_o,
  output logic [15:0]            drop_cnt_o
);

  localparam logic [2:0] LastK = 3'(NumCounters - 1);

  logic [2:0]             state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic [NumCounters-1:0] pend_q, pend_d;
  logic [63:0]            wdata_q, wdata_d;
  logic [63:0]            base_q, base_d;
  logic [15:0]            wr_ptr_q, wr_ptr_d;
  logic [15:0]            drop_q, drop_d;
  logic                   irq_q, irq_d;

  logic [NumCounters-1:0] trig_en;
  logic [NumCounters-1:0] start_mask;
  logic [15:0]            entries;
  logic [16:0]            wr_ptr_inc;
  logic [2:0]             word_idx;
  logic                   unused_cyc;

  assign unused_cyc = ^cycle_count_i[63:HDR_MASK_LSB];

  assign trig_en    = enable_i ? trig_i : '0;
  assign start_mask = trig_en | pend_q;
  assign entries    = (buf_entries_i == 16'd0) ? 16'd1 : buf_entries_i;
  assign wr_ptr_inc = {1'b0, wr_ptr_q} + 17'd1;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    pend_d   = pend_q;
    wdata_d  = wdata_q;
    base_d   = base_q;
    wr_ptr_d = wr_ptr_q;
    drop_d   = drop_q;

    // Pending only accumulates during a record; IDLE either consumes it or
    // discards it because enable is low.
    if (state_q == ST_IDLE) begin
      pend_d = '0;
    end else begin
      if (|(trig_en & pend_q) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
      pend_d = enable_i ? (pend_q | trig_i) : '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (|start_mask) begin
          wdata_d = {HDR_MASK_W'(start_mask), cycle_count_i[HDR_MASK_LSB-1:0]};
          base_d  = base_addr_i;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (mem_gnt_i) begin
          k_d     = 3'd0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        wdata_d = perf_rdata_i;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (mem_gnt_i) begin
          if (k_q == LastK) begin
            state_d = ST_CMPL;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = ST_RD;
          end
        end
      end
      ST_CMPL: begin
        wr_ptr_d = (wr_ptr_inc >= {1'b0, entries}) ? 16'd0 : wr_ptr_inc[15:0];
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Set wins over a coincident clear so a completion is never lost.
    irq_d = (state_q == ST_CMPL) | (irq_q & ~irq_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      k_q      <= 3'd0;
      pend_q   <= '0;
      wdata_q  <= 64'd0;
      base_q   <= 64'd0;
      wr_ptr_q <= 16'd0;
      drop_q   <= 16'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      pend_q   <= pend_d;
      wdata_q  <= wdata_d;
      base_q   <= base_d;
      wr_ptr_q <= wr_ptr_d;
      drop_q   <= drop_d;
      irq_q    <= irq_d;
    end
  end

  assign word_idx    = (state_q == ST_HDR) ? 3'd0 : (k_q + 3'd1);
  assign mem_req_o   = (state_q == ST_HDR) || (state_q == ST_WR);
  assign mem_addr_o  = mem_req_o ? rec_word_addr(base_q, wr_ptr_q, word_idx) : 64'd0;
  assign mem_wdata_o = mem_req_o ? wdata_q : 64'd0;
  assign perf_addr_o = (state_q == ST_RD) ? (CSR_MHPM_COUNTER_3 + {9'd0, k_q}) : 12'd0;
  assign busy_o      = (state_q != ST_IDLE);
  assign irq_o       = irq_q;
  assign wr_ptr_o    = wr_ptr_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_perf_snapshot_ctrl.sv
// Bench for perf_snapshot_ctrl: record-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_perf_snapshot_ctrl;

  localparam int N = 6;
  localparam logic [11:0] CSR3 = 12'hB03;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          enable_i;
  logic [N-1:0]  trig_i;
  logic [63:0]   cycle_count_i;
  logic [63:0]   base_addr_i;
  logic [15:0]   buf_entries_i;
  logic [11:0]   perf_addr_o;
  logic [63:0]   perf_rdata_i;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [63:0]   mem_addr_o;
  logic [63:0]   mem_wdata_o;
  logic          irq_o;
  logic          irq_clr_i;
  logic          busy_o;
  logic [15:0]   wr_ptr_o;
  logic [15:0]   drop_cnt_o;

  logic [63:0]   ctr_val [N];
  int            total = 0;
  int            bad = 0;

  perf_snapshot_ctrl #(.NumCounters(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .trig_i(trig_i),
    .cycle_count_i(cycle_count_i), .base_addr_i(base_addr_i),
    .buf_entries_i(buf_entries_i), .perf_addr_o(perf_addr_o),
    .perf_rdata_i(perf_rdata_i), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .irq_o(irq_o),
    .irq_clr_i(irq_clr_i), .busy_o(busy_o), .wr_ptr_o(wr_ptr_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Perf counter block: combinational read, garbage outside the counter window.
  always_comb begin
    perf_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < N; i++)
      if (perf_addr_o == CSR3 + 12'(i)) perf_rdata_i = ctr_val[i];
  end

  initial begin
    cycle_count_i = 64'hA5C3_0000_0000_1000;
    forever @(negedge clk_i) cycle_count_i = cycle_count_i + 64'd1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. A record is a walk through positions:
  // 0 = header offered, odd = counter fetch, even>0 = counter offered,
  // 2N+1 = completion. Offers need a grant to move on, everything else moves.
  bit            m_active = 0;
  int            m_pos = 0;
  logic [N-1:0]  m_mask = '0;
  logic [55:0]   m_hdr = '0;
  logic [63:0]   m_base = '0;
  logic [15:0]   m_ptr = '0;
  logic [N-1:0]  m_pend = '0;
  logic [15:0]   m_drop = '0;
  bit            m_irq = 0;
  logic [N-1:0]  m_t;
  int            m_ent;
  bit            m_set;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_active = 0; m_pos = 0; m_mask = '0; m_hdr = '0; m_base = '0;
      m_ptr = '0; m_pend = '0; m_drop = '0; m_irq = 0;
    end else begin
      m_t   = enable_i ? trig_i : '0;
      m_ent = (buf_entries_i == 16'd0) ? 1 : int'(buf_entries_i);
      m_set = 0;
      if (!m_active) begin
        if ((m_t | m_pend) != '0) begin
          m_mask = m_t | m_pend; m_hdr = cycle_count_i[55:0];
          m_base = base_addr_i; m_active = 1; m_pos = 0;
        end
        m_pend = '0;
      end else begin
        if (((m_t & m_pend) != '0) && (m_drop != 16'hFFFF)) m_drop = m_drop + 16'd1;
        m_pend = enable_i ? (m_pend | m_t) : '0;
        if (m_pos == 2*N+1) begin
          m_ptr = (int'(m_ptr) + 1 >= m_ent) ? 16'd0 : m_ptr + 16'd1;
          m_set = 1; m_active = 0;
        end else if (m_pos % 2 == 0) begin
          if (mem_gnt_i) m_pos++;
        end else begin
          m_pos++;
        end
      end
      m_irq = m_set | (m_irq & !irq_clr_i);
    end
  end

  bit           e_req;
  int           e_wi;
  logic [63:0]  e_addr, e_wdata;
  logic [11:0]  e_paddr;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      e_req   = m_active && (m_pos % 2 == 0) && (m_pos <= 2*N);
      e_wi    = m_pos / 2;
      e_addr  = e_req ? m_base + 64'(m_ptr) * 64 + 64'(e_wi) * 8 : 64'd0;
      e_wdata = !e_req ? 64'd0 : (e_wi == 0 ? {8'(m_mask), m_hdr} : ctr_val[e_wi-1]);
      e_paddr = (m_active && (m_pos % 2 == 1) && (m_pos < 2*N+1)) ? CSR3 + 12'((m_pos-1)/2) : 12'd0;
      chk("m_req",   64'(mem_req_o),   64'(e_req));
      chk("m_addr",  mem_addr_o,       e_addr);
      chk("m_wdata", mem_wdata_o,      e_wdata);
      chk("m_paddr", 64'(perf_addr_o), 64'(e_paddr));
      chk("m_busy",  64'(busy_o),      64'(m_active));
      chk("m_irq",   64'(irq_o),       64'(m_irq));
      chk("m_ptr",   64'(wr_ptr_o),    64'(m_ptr));
      chk("m_drop",  64'(drop_cnt_o),  64'(m_drop));
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin tick(); n++; end while ((busy_o || m_active) && n < 300);
    chk({nm, "_timeout"}, 64'(busy_o), 64'd0);
  endtask

  task automatic clr_irq();
    tick(); irq_clr_i = 1'b1;
    tick(); irq_clr_i = 1'b0;
    chk("irq_clr", 64'(irq_o), 64'd0);
  endtask

  task automatic do_reset();
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    enable_i = 1'b1; trig_i = '0; mem_gnt_i = 1'b1; irq_clr_i = 1'b0;
    base_addr_i = 64'h8000_0000; buf_entries_i = 16'd4;
    for (int i = 0; i < N; i++) ctr_val[i] = 64'h100 + 64'(i);
    #1 rst_i = 1'b1;
    tick(); tick();
    chk("rst_req",  64'(mem_req_o),  64'd0);
    chk("rst_busy", 64'(busy_o),     64'd0);
    chk("rst_irq",  64'(irq_o),      64'd0);
    chk("rst_ptr",  64'(wr_ptr_o),   64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    chk("rst_addr", mem_addr_o,      64'd0);
    chk("rst_pa",   64'(perf_addr_o), 64'd0);
    rst_i = 1'b0;

    // Basic record, gnt tied high
    tick(); trig_i = 6'b000100;
    tick(); trig_i = '0;
    chk("t1_hreq",  64'(mem_req_o), 64'd1);
    chk("t1_haddr", mem_addr_o, 64'h8000_0000);
    chk("t1_hmask", 64'(mem_wdata_o[63:56]), 64'h04);
    for (int j = 2; j <= 15; j++) begin
      tick();
      if (j >= 3 && j <= 13 && (j % 2 == 1)) begin
        chk("t1_waddr", mem_addr_o, 64'h8000_0000 + 64'(8 * ((j-3)/2 + 1)));
        chk("t1_wdata", mem_wdata_o, 64'h100 + 64'((j-3)/2));
      end
      if (j == 14) begin chk("t1_irq14", 64'(irq_o), 64'd0); chk("t1_busy14", 64'(busy_o), 64'd1); end
      if (j == 15) begin
        chk("t1_irq15", 64'(irq_o), 64'd1);
        chk("t1_ptr15", 64'(wr_ptr_o), 64'd1);
        chk("t1_busy15", 64'(busy_o), 64'd0);
      end
    end

    // Grant withheld three cycles on word 2
    clr_irq();
    tick(); trig_i = 6'b000100;
    for (int j = 1; j <= 18; j++) begin
      tick();
      if (j == 1) trig_i = '0;
      if (j == 5) mem_gnt_i = 1'b0;
      if (j == 8) mem_gnt_i = 1'b1;
      if (j >= 5 && j <= 7) begin
        chk("t2_req",  64'(mem_req_o), 64'd1);
        chk("t2_addr", mem_addr_o, 64'h8000_0050);
        chk("t2_data", mem_wdata_o, 64'h101);
      end
      if (j == 17) chk("t2_irq17", 64'(irq_o), 64'd0);
      if (j == 18) begin chk("t2_irq18", 64'(irq_o), 64'd1); chk("t2_ptr", 64'(wr_ptr_o), 64'd2); end
    end

    // Ring wrap with two entries
    do_reset();
    buf_entries_i = 16'd2;
    for (int i = 0; i < 3; i++) begin
      tick(); trig_i = 6'b001000;
      tick(); trig_i = '0;
      if (i == 2) chk("t3_hdr_addr", mem_addr_o, 64'h8000_0000);
      wait_idle("t3");
      if (i == 1) chk("t3_ptr_wrap", 64'(wr_ptr_o), 64'd0);
    end
    chk("t3_ptr", 64'(wr_ptr_o), 64'd1);

    // Same bit twice during one record
    buf_entries_i = 16'd4;
    tick(); trig_i = 6'b000010;
    for (int j = 1; j <= 32; j++) begin
      tick();
      trig_i = (j == 3 || j == 6) ? 6'b000001 : 6'b000000;
      if (j == 16) begin
        chk("t4_req",  64'(mem_req_o), 64'd1);
        chk("t4_mask", 64'(mem_wdata_o[63:56]), 64'h01);
        chk("t4_drop", 64'(drop_cnt_o), 64'd1);
      end
      if (j == 30 || j == 32) chk("t4_busy", 64'(busy_o), 64'd0);
    end

    // irq clear coincident with completion, then lone clear
    clr_irq();
    tick(); trig_i = 6'b000001;
    for (int j = 1; j <= 17; j++) begin
      tick();
      if (j == 1) trig_i = '0;
      irq_clr_i = (j == 14 || j == 16);
      if (j == 15) chk("t5_irq_kept", 64'(irq_o), 64'd1);
      if (j == 17) chk("t5_irq_clr", 64'(irq_o), 64'd0);
    end

    // Reset during a counter write
    tick(); trig_i = 6'b000010;
    tick(); trig_i = '0;
    wait_idle("t6a");
    tick(); trig_i = 6'b000100;
    tick(); trig_i = '0;
    tick(); tick();
    chk("t6_req_pre", 64'(mem_req_o), 64'd1);
    #2 rst_i = 1'b1;
    #1 chk("t6_req_async", 64'(mem_req_o), 64'd0);
    tick(); rst_i = 1'b0;
    tick();
    chk("t6_ptr",  64'(wr_ptr_o), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_irq",  64'(irq_o), 64'd0);

    // Random traffic against the model
    buf_entries_i = 16'd3;
    r = $urandom; base_addr_i = {32'h0000_0040, r[31:6], 6'b0};
    for (int i = 0; i < N; i++) ctr_val[i] = {$urandom, $urandom};
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      r = $urandom;
      trig_i    = ($urandom_range(0, 7) == 0) ? r[N-1:0] : '0;
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      enable_i  = ($urandom_range(0, 99) < 97);
      irq_clr_i = ($urandom_range(0, 15) == 0);
    end
    trig_i = '0; mem_gnt_i = 1'b1; irq_clr_i = 1'b0; enable_i = 1'b1;
    wait_idle("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
